// File: rtl/lzw_pkg.sv
// rtl/lzw_pkg.sv - shared widths, state encoding and byte-count helper for the unpacker
package lzw_pkg;

  localparam int WORD_W         = 64;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 8;
  localparam int CNT_W          = 4;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  // A count of 0 or anything above a full word means a full word
  function automatic logic [CNT_W-1:0] eff_nbytes(input logic [CNT_W-1:0] n);
    if (n == '0 || n > CNT_W'(BYTES_PER_WORD)) begin
      return CNT_W'(BYTES_PER_WORD);
    end
    return n;
  endfunction

endpackage

// File: rtl/shift_unpack_64_bit_if.sv
// rtl/shift_unpack_64_bit_if.sv - word-in / byte-out handshake bundle of the unpacker
interface shift_unpack_64_bit_if;
  import lzw_pkg::*;

  logic [WORD_W-1:0] in_data;
  logic [CNT_W-1:0]  in_nbytes;
  logic              in_valid;
  logic              in_ready;
  logic [BYTE_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;

  modport slave (
    input  in_data, in_nbytes, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last, busy
  );

  modport master (
    output in_data, in_nbytes, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last, busy
  );

endinterface

// File: rtl/shift_unpack_64_bit.sv
// rtl/shift_unpack_64_bit.sv - splits packed 64-bit words into a byte stream, one byte per handshake
module shift_unpack_64_bit
  import lzw_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  shift_unpack_64_bit_if.slave bus
);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic out_valid;
  logic out_last;
  logic xfer;
  logic accept;

  assign out_valid = (state_q == EMIT);
  assign out_last  = out_valid && (cnt_q == CNT_W'(1));
  assign xfer      = out_valid && bus.out_ready;

  // Taking a new word while the last byte leaves keeps the stream bubble-free
  assign bus.in_ready = (state_q == IDLE) || (xfer && out_last);
  assign accept       = bus.in_valid && bus.in_ready;

  assign bus.out_valid = out_valid;
  assign bus.out_last  = out_last;
  assign bus.busy      = out_valid;
  assign bus.out_data  = MSB_FIRST ? hold_q[WORD_W-1 -: BYTE_W] : hold_q[BYTE_W-1:0];

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = EMIT;
      hold_d  = bus.in_data;
      cnt_d   = eff_nbytes(bus.in_nbytes);
    end else if (xfer) begin
      hold_d = MSB_FIRST ? {hold_q[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}}
                         : {{BYTE_W{1'b0}}, hold_q[WORD_W-1:BYTE_W]};
      cnt_d  = cnt_q - CNT_W'(1);
      if (out_last) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_shift_unpack_64_bit.sv
// tb/tb_shift_unpack_64_bit.sv - directed and random checks of both emit orders against a byte-queue model
module tb_shift_unpack_64_bit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shift_unpack_64_bit_if if0 ();
  shift_unpack_64_bit_if if1 ();

  // The LSB-first instance gets the byte-reversed word, so both must emit the same stream
  function automatic logic [63:0] brev(input logic [63:0] w);
    logic [63:0] r;
    for (int k = 0; k < 8; k++) r[8*k +: 8] = w[63-8*k -: 8];
    return r;
  endfunction

  assign if1.in_data   = brev(if0.in_data);
  assign if1.in_nbytes = if0.in_nbytes;
  assign if1.in_valid  = if0.in_valid;
  assign if1.out_ready = if0.out_ready;

  shift_unpack_64_bit #(.MSB_FIRST(1'b1)) dut_msb (.clk(clk), .rst_n(rst_n), .bus(if0));
  shift_unpack_64_bit #(.MSB_FIRST(1'b0)) dut_lsb (.clk(clk), .rst_n(rst_n), .bus(if1));

  int errors = 0;
  int checks = 0;
  logic [7:0] cur[$];
  logic [7:0] got[$];
  logic [7:0] exp_stream[$];
  bit acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at posedge+1, check at negedge, advance the model at the edge
  task automatic cycle(input bit iv, input logic [63:0] d, input logic [3:0] n, input bit ordy);
    bit ev, el, eir;
    int ne;
    if0.in_valid = iv; if0.in_data = d; if0.in_nbytes = n; if0.out_ready = ordy;
    @(negedge clk);
    ev  = cur.size() != 0;
    el  = cur.size() == 1;
    eir = !ev || (el && ordy);
    chk("msb_out_valid", 64'(if0.out_valid), 64'(ev));
    chk("lsb_out_valid", 64'(if1.out_valid), 64'(ev));
    chk("msb_busy",      64'(if0.busy),      64'(ev));
    chk("msb_out_last",  64'(if0.out_last),  64'(el));
    chk("lsb_out_last",  64'(if1.out_last),  64'(el));
    chk("msb_in_ready",  64'(if0.in_ready),  64'(eir));
    chk("lsb_in_ready",  64'(if1.in_ready),  64'(eir));
    if (ev) begin
      chk("msb_out_data", 64'(if0.out_data), 64'(cur[0]));
      chk("lsb_out_data", 64'(if1.out_data), 64'(cur[0]));
      if (ordy) begin
        got.push_back(if0.out_data);
        void'(cur.pop_front());
      end
    end
    acc = iv && eir;
    if (acc) begin
      ne = (n == 0 || n > 8) ? 8 : int'(n);
      cur.delete();
      for (int k = 0; k < ne; k++) cur.push_back(d[63-8*k -: 8]);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [63:0] w;
    logic [3:0] rt_n [4];
    int budget;
    if0.in_valid = 1'b0; if0.in_data = '0; if0.in_nbytes = '0; if0.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(if0.out_valid), 64'd0);
    chk("rst_out_data",  64'(if0.out_data),  64'd0);
    chk("rst_lsb_data",  64'(if1.out_data),  64'd0);
    chk("rst_busy",      64'(if0.busy),      64'd0);
    rst_n = 1'b1;

    // Full word
    cycle(1'b1, 64'h0102030405060708, 4'd8, 1'b1);
    repeat (9) cycle(1'b0, {$urandom, $urandom}, 4'($urandom), 1'b1);

    // Partial word with junk in the unused bytes
    cycle(1'b1, {24'hAABBCC, 8'($urandom), $urandom}, 4'd3, 1'b1);
    repeat (4) cycle(1'b0, '0, '0, 1'b1);

    // Back-pressure mid-word
    cycle(1'b1, 64'h1122334455667788, 4'd8, 1'b1);
    repeat (3) cycle(1'b0, '0, '0, 1'b1);
    repeat (5) cycle(1'b0, {$urandom, $urandom}, 4'd8, 1'b0);
    repeat (6) cycle(1'b0, '0, '0, 1'b1);

    // Back-to-back words with random lengths
    repeat (30) cycle(1'b1, {$urandom, $urandom}, 4'($urandom), 1'b1);
    repeat (10) cycle(1'b0, '0, '0, 1'b1);

    // Round trip of a 32-byte stream, with out-of-range counts meaning full words
    got.delete();
    exp_stream.delete();
    for (int i = 0; i < 32; i++) exp_stream.push_back(i < 16 ? 8'hFF : 8'h0A);
    rt_n[0] = 4'd8; rt_n[1] = 4'd0; rt_n[2] = 4'd9; rt_n[3] = 4'd15;
    for (int k = 0; k < 4; k++) begin
      w = (k < 2) ? 64'hFFFFFFFFFFFFFFFF : 64'h0A0A0A0A0A0A0A0A;
      budget = 20;
      acc = 1'b0;
      while (!acc && budget > 0) begin
        cycle(1'b1, w, rt_n[k], 1'b1);
        budget--;
      end
      chk("rt_accept_timeout", 64'(acc), 64'd1);
    end
    repeat (10) cycle(1'b0, '0, '0, 1'b1);
    chk("rt_count", 64'(got.size()), 64'd32);
    for (int i = 0; i < 32 && i < got.size(); i++) chk("rt_byte", 64'(got[i]), 64'(exp_stream[i]));

    // Reset after three of eight bytes
    cycle(1'b1, 64'hA1A2A3A4A5A6A7A8, 4'd8, 1'b1);
    repeat (3) cycle(1'b0, '0, '0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(if0.out_valid), 64'd0);
    chk("midrst_lsb_valid", 64'(if1.out_valid), 64'd0);
    chk("midrst_out_data",  64'(if0.out_data),  64'd0);
    chk("midrst_busy",      64'(if0.busy),      64'd0);
    cur.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle(1'b0, '0, '0, 1'b1);
    cycle(1'b1, 64'hB1B2B3B4B5B6B7B8, 4'd8, 1'b1);
    repeat (9) cycle(1'b0, '0, '0, 1'b1);

    // Random traffic
    repeat (500) cycle(1'($urandom), {$urandom, $urandom}, 4'($urandom), 1'($urandom_range(0, 3) != 0));
    repeat (12) cycle(1'b0, '0, '0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_unpack_64_bit.md
SHIFT_UNPACK_64_BIT -- requirements
Module: shift_unpack_64_bit

Interface
REQ-001 Parameter MSB_FIRST, default 1, selects the emit order: 1 emits byte [63:56] first; 0 emits byte [7:0] first.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_data  input  64  packed word; first byte in packer order sits in [63:56].
REQ-005 in_nbytes  input  4  count of valid bytes in in_data; 1..8 are used as given, 0 and 9..15 are treated as 8.
REQ-006 in_valid  input  1  in_data and in_nbytes are valid this cycle.
REQ-007 in_ready  output  1  block accepts a word this cycle.
REQ-008 out_data  output  8  current byte.
REQ-009 out_valid  output  1  out_data is valid.
REQ-010 out_ready  input  1  consumer accepts out_data this cycle.
REQ-011 out_last  output  1  out_data is the final byte of the current word.
REQ-012 busy  output  1  a word is held and not yet fully emitted.

Function
REQ-013 States: IDLE (no word held) and EMIT (word held, bytes remaining is 1 or more).
REQ-014 A word is accepted on a rising edge where in_valid and in_ready are both 1. It is then captured into a 64-bit hold register, and the remaining-byte counter is set to the effective in_nbytes.
REQ-015 Byte transfer happens on a rising edge where out_valid and out_ready are both 1. Each transfer shifts the hold register by 8 bits toward the emit end and decrements the counter.
REQ-016 With MSB_FIRST=1, the valid bytes of a partial word occupy [63:64-8*n]; with MSB_FIRST=0 they occupy [8*n-1:0]. Unused bytes are ignored.
REQ-017 out_data is taken directly from the emit end of the hold register, so a word's first byte is valid the cycle after acceptance (latency 1).
REQ-018 out_valid = (state == EMIT); busy = out_valid.
REQ-019 out_last = out_valid and (counter == 1).
REQ-020 in_ready = (state == IDLE) or (out_valid and out_last and out_ready). This gives back-to-back words with no bubble; the combinational path from out_ready to in_ready is intended.
REQ-021 If the final-byte transfer and a new word acceptance occur on the same edge, the block stays in EMIT with the new word loaded.
REQ-022 If the final byte transfers and no word is accepted, the block goes to IDLE.
REQ-023 While out_valid=1 and out_ready=0, out_data, out_last and the hold register stay stable.
REQ-024 in_data and in_nbytes are ignored whenever in_ready=0.
REQ-025 The counter never underflows, because no transfer occurs in IDLE.

Reset
REQ-026 Asserting rst_n=0 immediately forces: state IDLE, hold register 0, counter 0, out_valid 0, out_last 0, busy 0, out_data 8'h00, and in_ready 1 once rst_n is released.
REQ-027 Reset asserted mid-word discards the remaining bytes; no partial byte is emitted after release.
REQ-028 Deassertion of rst_n is assumed to be synchronised externally to clk.

Structure
REQ-029 WORD_W=64, BYTE_W=8, BYTES_PER_WORD=8, CNT_W=4 and the state enum (IDLE, EMIT) belong in the shared package lzw_pkg.
REQ-030 The block is a single module with no sub-module; the 120-200 line RTL budget is sufficient.

Verification
REQ-031 Full word: in_data=64'h0102030405060708, in_nbytes=8, out_ready=1 -> outputs 01,02,...,08 on 8 consecutive cycles starting 1 cycle after acceptance, with out_last only on 08.
REQ-032 Round trip: push 16 bytes of 8'hFF then 16 of 8'h0A through the packer and feed its words here -> identical 32-byte stream in order.
REQ-033 Partial word: in_nbytes=3 with word 64'hAABBCC0000000000 -> AA, BB, CC with out_last on CC, then IDLE.
REQ-034 Back-pressure: hold out_ready=0 for 5 cycles mid-word -> out_data stable and no byte lost or duplicated.
REQ-035 Back-to-back: second word valid during the last byte -> in_ready=1 on that cycle and the next word's first byte on the following cycle with no bubble.
REQ-036 Reset after 3 of 8 bytes -> out_valid=0 immediately; after release, a new word emits from its first byte.
